// File: rtl/pi_link_master_pkg.sv
// Shared types and constants for the PI link master.
// State encodings, link defaults and host command codes.
package pi_link_master_pkg;

    localparam int SETUP_CYCLES_DEF = 2;
    localparam int LEN_W            = 5;

    typedef enum logic [3:0] {
        IDLE,
        TX_SETUP,
        TX_LOW,
        TX_HIGH,
        TX_TAIL,
        RX_SETUP,
        RX_HIGH,
        RX_LOW,
        RX_DONE
    } state_t;

    typedef enum logic [15:0] {
        ROMCS_CMD = 16'h0008,
        RESET_CMD = 16'h0002
    } cmd_t;

    // A zero or oversized length means a full-width word.
    function automatic logic [LEN_W-1:0] eff_len(
        input logic [LEN_W-1:0] len,
        input int               max_bits
    );
        if (len == '0 || int'(len) > max_bits)
            return LEN_W'(max_bits);
        return len;
    endfunction

endpackage

// File: rtl/pi_link_master_if.sv
// Host handshake and PI line signals of the link master.
// master = link controller, slave = host plus line partner.
interface pi_link_master_if
    import pi_link_master_pkg::*;
#(
    parameter int W  = 16,
    parameter int LW = LEN_W
);
    logic          tx_valid;
    logic          tx_ready;
    logic [W-1:0]  tx_data;
    logic [LW-1:0] tx_len;
    logic          tx_done;
    logic          rx_valid;
    logic [W-1:0]  rx_data;
    logic [LW-1:0] rx_len;
    logic          PI_MOSI;
    logic          PI_IO_CLK;
    logic          PI_IO_O;
    logic          PI_IO_OE;
    logic          PI_IO_I;
    logic          PI_MISO;

    modport master (
        input  tx_valid, tx_data, tx_len, PI_IO_I, PI_MISO,
        output tx_ready, tx_done, rx_valid, rx_data, rx_len,
        output PI_MOSI, PI_IO_CLK, PI_IO_O, PI_IO_OE
    );

    modport slave (
        output tx_valid, tx_data, tx_len, PI_IO_I, PI_MISO,
        input  tx_ready, tx_done, rx_valid, rx_data, rx_len,
        input  PI_MOSI, PI_IO_CLK, PI_IO_O, PI_IO_OE
    );

endinterface

// File: rtl/pi_link_shreg.sv
// Bit shift register with bit counter for the PI link.
// Parallel load, MSB shift-out, LSB shift-in with saturating count.
module pi_link_shreg #(
    parameter int W  = 16,
    parameter int CW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          load,
    input  logic [W-1:0]  load_data,
    input  logic [CW-1:0] load_cnt,
    input  logic          shift_out,
    input  logic          shift_in,
    input  logic          din,
    output logic [W-1:0]  q,
    output logic [CW-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            q   <= '0;
            cnt <= '0;
        end else if (load) begin
            q   <= load_data;
            cnt <= load_cnt;
        end else if (shift_out) begin
            q   <= {q[W-2:0], 1'b0};
            cnt <= cnt - CW'(1);
        end else if (shift_in) begin
            q <= {q[W-2:0], din};
            if (cnt != '1)
                cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/pi_link_master.sv
// PI link master: MOSI frames from the host, MISO frames from the partner.
// Define PI_LINK_RX_LIMIT_EN to end RX after MAX_BITS bits.
module pi_link_master
    import pi_link_master_pkg::*;
#(
    parameter int SETUP_CYCLES = SETUP_CYCLES_DEF,
    parameter int MAX_BITS     = 16
) (
    input  logic               PI_MASTER_CLK,
    input  logic               PI_RESET,
    pi_link_master_if.master   bus
);

    state_t              state;
    state_t              state_nxt;
    logic [7:0]          setup_cnt;
    logic                setup_last;
    logic                tx_done_q;
    logic                tx_load;
    logic                tx_shift;
    logic                rx_clr;
    logic                rx_shift;
    logic                rx_at_limit;
    logic [LEN_W-1:0]    tx_n;
    logic [LEN_W-1:0]    tx_cnt;
    logic [LEN_W-1:0]    rx_cnt;
    logic [MAX_BITS-1:0] tx_q;
    logic [MAX_BITS-1:0] rx_q;
    logic [MAX_BITS-1:0] tx_ld;
    logic                unused_tx_q;

    assign setup_last  = setup_cnt == 8'(SETUP_CYCLES - 1);
    assign tx_n        = eff_len(bus.tx_len, MAX_BITS);
    // Left-justify so the first bit to send sits in the MSB.
    assign tx_ld       = bus.tx_data << (MAX_BITS - int'(tx_n));
    assign unused_tx_q = ^tx_q[MAX_BITS-2:0];

`ifdef PI_LINK_RX_LIMIT_EN
    assign rx_at_limit = rx_cnt == LEN_W'(MAX_BITS - 1);
`else
    assign rx_at_limit = 1'b0;
`endif

    always_ff @(posedge PI_MASTER_CLK) begin
        if (PI_RESET)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge PI_MASTER_CLK) begin
        if (PI_RESET) begin
            setup_cnt <= '0;
            tx_done_q <= 1'b0;
        end else begin
            if (state == TX_SETUP || state == RX_SETUP)
                setup_cnt <= setup_cnt + 8'd1;
            else
                setup_cnt <= '0;
            tx_done_q <= state == TX_TAIL;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (bus.PI_MISO)
                    state_nxt = RX_SETUP;
                else if (bus.tx_valid)
                    state_nxt = TX_SETUP;
            end
            TX_SETUP: if (setup_last) state_nxt = TX_LOW;
            TX_LOW:   state_nxt = TX_HIGH;
            TX_HIGH: begin
                if (tx_cnt == LEN_W'(1))
                    state_nxt = TX_TAIL;
                else
                    state_nxt = TX_LOW;
            end
            TX_TAIL:  state_nxt = IDLE;
            RX_SETUP: if (setup_last) state_nxt = RX_HIGH;
            RX_HIGH:  state_nxt = RX_LOW;
            RX_LOW: begin
                if (!bus.PI_MISO || rx_at_limit)
                    state_nxt = RX_DONE;
                else
                    state_nxt = RX_HIGH;
            end
`ifdef PI_LINK_RX_LIMIT_EN
            RX_DONE: if (!bus.PI_MISO) state_nxt = IDLE;
`else
            RX_DONE:  state_nxt = IDLE;
`endif
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.PI_MOSI   = 1'b0;
        bus.PI_IO_CLK = 1'b0;
        bus.PI_IO_O   = 1'b0;
        bus.rx_valid  = 1'b0;
        tx_load       = 1'b0;
        tx_shift      = 1'b0;
        rx_clr        = 1'b0;
        rx_shift      = 1'b0;
        unique case (state)
            IDLE: begin
                tx_load = !bus.PI_MISO && bus.tx_valid;
                rx_clr  = bus.PI_MISO;
            end
            TX_SETUP: bus.PI_MOSI = 1'b1;
            TX_LOW: begin
                bus.PI_MOSI = 1'b1;
                bus.PI_IO_O = tx_q[MAX_BITS-1];
            end
            TX_HIGH: begin
                bus.PI_MOSI   = 1'b1;
                bus.PI_IO_CLK = 1'b1;
                bus.PI_IO_O   = tx_q[MAX_BITS-1];
                tx_shift      = 1'b1;
            end
            TX_TAIL:  bus.PI_MOSI   = 1'b1;
            RX_HIGH:  bus.PI_IO_CLK = 1'b1;
            RX_LOW:   rx_shift      = 1'b1;
`ifdef PI_LINK_RX_LIMIT_EN
            RX_DONE:  bus.rx_valid  = !bus.PI_MISO;
`else
            RX_DONE:  bus.rx_valid  = 1'b1;
`endif
            default: ;
        endcase
    end

    assign bus.PI_IO_OE = bus.PI_MOSI && !bus.PI_MISO;
    assign bus.tx_ready = state == IDLE && !bus.PI_MISO;
    assign bus.tx_done  = tx_done_q;
    assign bus.rx_data  = rx_q;
    assign bus.rx_len   = rx_cnt;

    pi_link_shreg #(.W(MAX_BITS), .CW(LEN_W)) u_tx (
        .clk       (PI_MASTER_CLK),
        .rst       (PI_RESET),
        .clr       (1'b0),
        .load      (tx_load),
        .load_data (tx_ld),
        .load_cnt  (tx_n),
        .shift_out (tx_shift),
        .shift_in  (1'b0),
        .din       (1'b0),
        .q         (tx_q),
        .cnt       (tx_cnt)
    );

    pi_link_shreg #(.W(MAX_BITS), .CW(LEN_W)) u_rx (
        .clk       (PI_MASTER_CLK),
        .rst       (PI_RESET),
        .clr       (rx_clr),
        .load      (1'b0),
        .load_data ('0),
        .load_cnt  ('0),
        .shift_out (1'b0),
        .shift_in  (rx_shift),
        .din       (bus.PI_IO_I),
        .q         (rx_q),
        .cnt       (rx_cnt)
    );

endmodule

// File: tb/tb_pi_link_master.sv
// Randomized bench for pi_link_master against a frame-timeline model.
// Honors PI_LINK_RX_LIMIT_EN when defined.
module tb_pi_link_master;
    import pi_link_master_pkg::*;

    localparam int S  = 2;
    localparam int MB = 16;
`ifdef PI_LINK_RX_LIMIT_EN
    localparam bit LIMIT = 1'b1;
`else
    localparam bit LIMIT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    pi_link_master_if bus ();

    pi_link_master #(.SETUP_CYCLES(S), .MAX_BITS(MB)) dut (
        .PI_MASTER_CLK (clk),
        .PI_RESET      (rst),
        .bus           (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Model: current frame kind, first cycle of frame, payload, rx result.
    typedef enum int {M_IDLE, M_TX, M_RX} mkind_t;
    mkind_t      m_kind   = M_IDLE;
    int          m_start  = 0;
    int          m_n      = 0;
    logic [15:0] m_word   = '0;
    logic [15:0] m_rxd    = '0;
    int          m_rxl    = 0;
    bit          m_rxend  = 0;
    bit          m_txdone = 0;
    bit          m_live   = 0;
    int          m_acc    = 0;

    always @(posedge clk) begin
        int off;
        cyc++;
        m_txdone = 0;
        off = cyc - 1 - m_start;
        if (rst) begin
            m_kind  = M_IDLE;
            m_rxd   = '0;
            m_rxl   = 0;
            m_rxend = 0;
            m_live  = 1;
        end else if (m_live) begin
            case (m_kind)
                M_IDLE: begin
                    if (bus.PI_MISO) begin
                        m_kind = M_RX; m_start = cyc;
                        m_rxd = '0; m_rxl = 0; m_rxend = 0;
                    end else if (bus.tx_valid) begin
                        m_kind = M_TX; m_start = cyc; m_acc++;
                        m_n = (bus.tx_len == 0) ? 16 : int'(bus.tx_len);
                        m_word = bus.tx_data;
                    end
                end
                M_TX: begin
                    if (off == S + 2 * m_n) begin
                        m_kind = M_IDLE; m_txdone = 1;
                    end
                end
                M_RX: begin
                    if (m_rxend) begin
                        if (!LIMIT || !bus.PI_MISO) m_kind = M_IDLE;
                    end else if (off >= S && (off - S) % 2 == 1) begin
                        m_rxd = {m_rxd[14:0], bus.PI_IO_I};
                        if (m_rxl < 31) m_rxl++;
                        if (!bus.PI_MISO || (LIMIT && m_rxl == MB))
                            m_rxend = 1;
                    end
                end
                default: ;
            endcase
        end
    end

    logic [27:0] e_vec, a_vec;

    always @(negedge clk) begin
        int off, k;
        bit mosi, ck, o, rv, rdy, oe;
        if (m_live) begin
            mosi = 0; ck = 0; o = 0; rv = 0;
            off = cyc - m_start;
            if (m_kind == M_TX) begin
                mosi = 1;
                if (off >= S && off < S + 2 * m_n) begin
                    k  = off - S;
                    ck = (k % 2) == 1;
                    o  = m_word[m_n - 1 - k / 2];
                end
            end else if (m_kind == M_RX) begin
                if (m_rxend)
                    rv = LIMIT ? !bus.PI_MISO : 1'b1;
                else if (off >= S)
                    ck = ((off - S) % 2) == 0;
            end
            rdy = (m_kind == M_IDLE) && !bus.PI_MISO;
            oe  = mosi && !bus.PI_MISO;
            e_vec = {rdy, m_txdone, rv, mosi, ck, o, oe, m_rxd, 5'(m_rxl)};
            a_vec = {bus.tx_ready, bus.tx_done, bus.rx_valid, bus.PI_MOSI,
                     bus.PI_IO_CLK, bus.PI_IO_O, bus.PI_IO_OE,
                     bus.rx_data, bus.rx_len};
            checks++;
            if (a_vec !== e_vec) begin
                errors++;
                $display("FAIL cycle %0d outputs: got %h want %h", cyc, a_vec, e_vec);
            end
        end
    end

    // Observation counters for the directed literal checks.
    int          mon_mosi, mon_clk, mon_done, mon_rxv, mon_oe_miso;
    int          mon_rxv_cyc, mon_mosi_cyc;
    logic [31:0] mon_bits;
    bit          prev_clk = 0;

    always @(negedge clk) begin
        if (bus.PI_MOSI === 1'b1) begin
            mon_mosi++;
            if (mon_mosi_cyc < 0) mon_mosi_cyc = cyc;
        end
        if (bus.PI_IO_CLK === 1'b1 && !prev_clk) begin
            mon_clk++;
            if (bus.PI_MOSI === 1'b1) mon_bits = {mon_bits[30:0], bus.PI_IO_O};
        end
        prev_clk = (bus.PI_IO_CLK === 1'b1);
        if (bus.tx_done === 1'b1) mon_done++;
        if (bus.rx_valid === 1'b1) begin
            mon_rxv++;
            if (mon_rxv_cyc < 0) mon_rxv_cyc = cyc;
        end
        if (bus.PI_IO_OE === 1'b1 && bus.PI_MISO) mon_oe_miso++;
    end

    task automatic clr_mon();
        mon_mosi = 0; mon_clk = 0; mon_done = 0; mon_rxv = 0;
        mon_oe_miso = 0; mon_bits = '0;
        mon_rxv_cyc = -1; mon_mosi_cyc = -1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out", name);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (m_kind != M_IDLE && t < 300) begin tick(); t++; end
        if (m_kind != M_IDLE) timeout("wait_idle");
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic send_tx(input logic [15:0] data, input logic [4:0] len);
        int a0 = m_acc;
        int t  = 0;
        bus.tx_data  = data;
        bus.tx_len   = len;
        bus.tx_valid = 1'b1;
        do begin tick(); t++; end while (m_acc == a0 && t < 400);
        bus.tx_valid = 1'b0;
        if (m_acc == a0) timeout("tx_accept");
    endtask

    // Line partner: holds PI_MISO while it has bits, one per PI_IO_CLK pulse.
    task automatic partner_rx(input int nb, input logic [31:0] word, input bit early);
        int t = 0;
        bus.PI_MISO = 1'b1;
        while (m_kind != M_RX && t < 400) begin tick(); t++; end
        if (m_kind != M_RX) begin
            timeout("rx_start");
            bus.PI_MISO = 1'b0;
            return;
        end
        if (early) bus.PI_MISO = 1'b0;
        for (int i = 0; i < nb; i++) begin
            t = 0;
            while (bus.PI_IO_CLK !== 1'b1 && t < S + 6) begin tick(); t++; end
            if (bus.PI_IO_CLK !== 1'b1) begin
                if (!(LIMIT && i == MB)) timeout("rx_bit_clock");
                bus.PI_MISO = 1'b0;
                break;
            end
            bus.PI_IO_I = word[nb - 1 - i];
            if (i == nb - 1 || early) bus.PI_MISO = 1'b0;
            tick();
        end
    endtask

    initial begin
        bus.tx_valid = 1'b0;
        bus.tx_data  = '0;
        bus.tx_len   = '0;
        bus.PI_MISO  = 1'b0;
        bus.PI_IO_I  = 1'b0;
        clr_mon();
        tick(3);
        rst = 1'b0;

        chk("reset_tx_ready", 32'(bus.tx_ready), 32'd1);
        chk("reset_mosi", 32'(bus.PI_MOSI), 32'd0);
        chk("reset_rx", {11'd0, bus.rx_len, bus.rx_data}, 32'd0);

        clr_mon();
        send_tx(ROMCS_CMD | RESET_CMD, 5'd4);
        wait_idle(); tick(2);
        chk("cmd_bits", mon_bits, 32'hA);
        chk("cmd_clks", mon_clk, 32'd4);
        chk("cmd_mosi", mon_mosi, 32'd11);
        chk("cmd_done", mon_done, 32'd1);

        clr_mon();
        send_tx(16'h00CD, 5'd8);
        wait_idle(); tick(2);
        chk("cd_bits", mon_bits, 32'hCD);
        chk("cd_mosi", mon_mosi, 32'd19);
        chk("cd_done", mon_done, 32'd1);

        clr_mon();
        partner_rx(16, 32'hA5C3, 0);
        wait_idle(); tick(1);
        chk("rx16_data", 32'(bus.rx_data), 32'hA5C3);
        chk("rx16_len", 32'(bus.rx_len), 32'd16);
        chk("rx16_valid", mon_rxv, 32'd1);

        clr_mon();
        partner_rx(20, 32'hB1E2D, 0);
        wait_idle(); tick(1);
        if (LIMIT) begin
            chk("rx20_len", 32'(bus.rx_len), 32'd16);
            chk("rx20_data", 32'(bus.rx_data), 32'hB1E2);
            chk("rx20_clks", mon_clk, 32'd16);
        end else begin
            chk("rx20_len", 32'(bus.rx_len), 32'd20);
            chk("rx20_data", 32'(bus.rx_data), 32'h1E2D);
            chk("rx20_clks", mon_clk, 32'd20);
        end

        clr_mon();
        fork
            send_tx(16'h005A, 5'd8);
            partner_rx(4, 32'h9, 0);
        join
        wait_idle(); tick(2);
        chk("prio_rx_first", 32'(mon_rxv_cyc >= 0 && mon_rxv_cyc < mon_mosi_cyc), 32'd1);
        chk("prio_done", mon_done, 32'd1);
        chk("prio_oe_miso", mon_oe_miso, 32'd0);
        chk("prio_rx", {11'd0, bus.rx_len, bus.rx_data}, {11'd0, 5'd4, 16'h0009});

        clr_mon();
        fork
            send_tx(16'h01F0, 5'd12);
            begin tick(6); partner_rx(3, 32'h5, 0); end
        join
        wait_idle(); tick(2);
        chk("midtx_rx", {11'd0, bus.rx_len, bus.rx_data}, {11'd0, 5'd3, 16'h0005});
        chk("midtx_oe_miso", mon_oe_miso, 32'd0);

        partner_rx(1, 32'h1, 1);
        wait_idle(); tick(1);
        chk("early_drop_rx", {11'd0, bus.rx_len, bus.rx_data}, {11'd0, 5'd1, 16'h0001});

        clr_mon();
        send_tx(16'h00B6, 5'd8);
        tick(S + 6);
        pulse_reset();
        chk("rst_outs", {bus.PI_MOSI, bus.PI_IO_CLK, bus.PI_IO_O, bus.tx_done, bus.rx_valid},
            32'd0);
        chk("rst_rx", {11'd0, bus.rx_len, bus.rx_data}, 32'd0);
        tick(30);
        chk("rst_no_done", mon_done, 32'd0);

        clr_mon();
        send_tx(16'h8001, 5'd0);
        wait_idle(); tick(2);
        chk("len0_bits", mon_bits[15:0], 32'h8001);
        chk("len0_mosi", mon_mosi, 32'(S + 33));

        for (int it = 0; it < 60; it++) begin
            int          op  = $urandom_range(0, 4);
            logic [15:0] d   = 16'($urandom);
            logic [4:0]  len = 5'($urandom_range(0, 16));
            case (op)
                0, 1: send_tx(d, len);
                2: partner_rx($urandom_range(1, 24), $urandom, 0);
                3: fork
                    send_tx(d, len);
                    partner_rx($urandom_range(1, 20), $urandom, 0);
                join
                default: begin
                    send_tx(d, len);
                    tick($urandom_range(0, S + 2 * 16));
                    pulse_reset();
                end
            endcase
            wait_idle();
            tick($urandom_range(0, 3));
        end

        tick(4);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
